mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-stage data-access engine between the EX/MEM register and the MEM/WB register. It turns the EX-stage address and store data into a single-outstanding request/acknowledge transaction on the data-memory bus. It stalls the pipeline until the access completes. It formats load data (byte/half/word, signed/unsigned, little-endian) into the registered word the MEM/WB register captures as its memory-data input.

## Interface
Parameters:
- none (widths fixed: 32-bit data/address bus, 4 byte lanes)

Ports:
- Clock and reset: one clock, `in_CLK`; reset `in_CLR_N` is asynchronous and active-low.
- in_CLK  input  1  stage clock, rising edge
- in_CLR_N  input  1  asynchronous active-low reset
- in_EN  input  1  pipeline advance; high = MEM/WB captures this cycle
- in_memread  input  1  current instruction is a load
- in_memwrite  input  1  current instruction is a store (in_memread and in_memwrite never both high)
- in_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
- in_unsigned  input  1  zero-extend loads when high, sign-extend when low
- in_addr  input  32  byte address (ALU result)
- in_wdata  input  32  store data (rb)
- in_mem_ack  input  1  bus acknowledge; read data valid in the same cycle
- in_mem_rdata  input  32  bus read word
- out_mem_req  output  1  registered request, held until ack
- out_mem_we  output  1  registered write enable
- out_mem_addr  output  32  registered word address, {in_addr[31:2],2'b00}
- out_mem_be  output  4  registered byte enables
- out_mem_wdata  output  32  registered lane-replicated store data
- out_Memdata  output  32  registered formatted load result
- out_stall  output  1  combinational; high = hold pipeline
- out_misalign  output  1  combinational misalignment flag (see Configuration)

## Operation
- States: IDLE, REQ, DONE. Reset: state IDLE, all registered outputs 0.
- IDLE: if (in_memread|in_memwrite) and not misaligned, go to REQ. On that edge, latch addr/be/wdata/we and set out_mem_req=1. Otherwise stay in IDLE.
- REQ: bus outputs held stable. On in_mem_ack: clear req/we; if load, register formatted data into out_Memdata; go to DONE. No ack: stay, unbounded.
- DONE: if in_EN go to IDLE, else stay. out_Memdata held.
- out_stall = (in_memread|in_memwrite) & ~misaligned & (state != DONE).
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],1'b0}
  - word: 1111
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word as-is.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1] (bits [15:0] or [31:16]).
  - Extend to 32 bits per in_unsigned.
- out_Memdata changes only on a load ack. Stores and non-memory instructions leave it unchanged.
- Reset mid-transaction: immediate return to IDLE with req dropped. The bus slave must tolerate the abandoned request.

## Timing
- Minimum access = 2 stall cycles. Cycle 0: op presented, stall=1. Cycle 1: req=1, ack arrives. Cycle 2: DONE, stall=0, MEM/WB captures out_Memdata.
- Each extra wait cycle before ack adds one stall cycle.
- Back-to-back memory ops: DONE→IDLE on the in_EN edge. The next op starts from IDLE on the following cycle, which is one idle bus cycle between requests.
- in_EN low in DONE (downstream stall): result held indefinitely; no new request issued.
- ack is ignored in IDLE and DONE.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - out_misalign = access & ((half & addr[0]) | (word & addr[1:0]!=0)).
  - A misaligned access issues no request and raises no stall. State stays IDLE and out_Memdata is unchanged; the trap unit consumes out_misalign.
- Undefined:
  - out_misalign tied 0.
  - Half access ignores addr[0]; word access ignores addr[1:0].
  - Every access issues a request.

## Test plan
- Word load, addr 0x100, rdata 0xDEADBEEF, ack in REQ cycle → req high 1 cycle, out_mem_addr=0x100, be=1111. out_Memdata=0xDEADBEEF in cycle 2, stall low in cycle 2.
- Signed byte load, addr 0x103, rdata 0x80FF0000 → be=1000, out_Memdata=0xFFFFFF80. Repeat with in_unsigned=1 → 0x00000080.
- Half store, addr 0x202, wdata 0x1234ABCD, ack after 3 wait cycles → out_mem_we=1, be=1100, out_mem_wdata=0xABCDABCD, stall high 5 cycles. out_Memdata unchanged.
- Ack received with in_EN low for 4 cycles → state holds DONE, no second request, out_Memdata stable. in_EN high → IDLE next cycle.
- in_CLR_N pulsed low while REQ → req, we, be, out_Memdata drop to 0 immediately; state IDLE after release.
- Word load at 0x102: with MEM_ALIGN_CHECK_EN → out_misalign=1, no req, stall=0. Without it → req issued to 0x100.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-stage data-access engine.
// Issues one outstanding req/ack bus transaction per load/store, stalls the
// pipeline until it completes and formats load data for the MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (enables misalignment detection).
module mem_access_stage (
  input  logic        in_CLK,
  input  logic        in_CLR_N,
  input  logic        in_EN,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_mem_ack,
  input  logic [31:0] in_mem_rdata,
  output logic        out_mem_req,
  output logic        out_mem_we,
  output logic [31:0] out_mem_addr,
  output logic [3:0]  out_mem_be,
  output logic [31:0] out_mem_wdata,
  output logic [31:0] out_Memdata,
  output logic        out_stall,
  output logic        out_misalign
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t          r_state;
  logic            r_req;
  logic            r_we;
  logic [DW-1:0]   r_addr;
  logic [BW-1:0]   r_be;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_memdata;
  logic            r_load;
  logic [1:0]      r_lsize;
  logic [1:0]      r_lane;
  logic            r_uns;

  logic            w_access;
  logic            w_is_byte;
  logic            w_is_half;
  logic            w_is_word;
  logic            w_misalign;
  logic            w_start;
  logic [BW-1:0]   w_be;
  logic [DW-1:0]   w_wdata;
  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;
  logic [DW-1:0]   w_ld_data;

  assign w_access  = in_memread | in_memwrite;
  assign w_is_byte = (in_size == 2'b00);
  assign w_is_half = (in_size == 2'b01);
  assign w_is_word = in_size[1];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access &
                      ((w_is_half & in_addr[0]) | (w_is_word & (in_addr[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start      = w_access & ~w_misalign;
  assign out_stall    = w_start & (r_state != S_DONE);
  assign out_misalign = w_misalign;

  // Byte enables and lane-replicated store data for the current access
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = in_wdata;
    if (w_is_byte) begin
      w_be    = 4'b0001 << in_addr[1:0];
      w_wdata = {4{in_wdata[7:0]}};
    end else if (w_is_half) begin
      w_be    = in_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{in_wdata[15:0]}};
    end
  end

  // Extract and extend the load result from the bus word using latched attributes
  always_comb begin
    w_ld_byte = in_mem_rdata[7:0];
    case (r_lane)
      2'd1:    w_ld_byte = in_mem_rdata[15:8];
      2'd2:    w_ld_byte = in_mem_rdata[23:16];
      2'd3:    w_ld_byte = in_mem_rdata[31:24];
      default: w_ld_byte = in_mem_rdata[7:0];
    endcase
    w_ld_half = r_lane[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    if (r_lsize[1]) begin
      w_ld_data = in_mem_rdata;
    end else if (r_lsize[0]) begin
      w_ld_data = {{16{~r_uns & w_ld_half[15]}}, w_ld_half};
    end else begin
      w_ld_data = {{24{~r_uns & w_ld_byte[7]}}, w_ld_byte};
    end
  end

  // Access FSM with registered bus outputs and load result
  always_ff @(posedge in_CLK or negedge in_CLR_N) begin
    if (!in_CLR_N) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_memdata <= '0;
      r_load    <= 1'b0;
      r_lsize   <= 2'b00;
      r_lane    <= 2'b00;
      r_uns     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_we    <= in_memwrite;
            r_addr  <= {in_addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_load  <= in_memread;
            r_lsize <= in_size;
            r_lane  <= in_addr[1:0];
            r_uns   <= in_unsigned;
          end
        end
        S_REQ: begin
          if (in_mem_ack) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            if (r_load) begin
              r_memdata <= w_ld_data;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (in_EN) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_mem_req   = r_req;
  assign out_mem_we    = r_we;
  assign out_mem_addr  = r_addr;
  assign out_mem_be    = r_be;
  assign out_mem_wdata = r_wdata;
  assign out_Memdata   = r_memdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus scoreboard,
// followed by hand-written hold, misalignment and reset sequences.
module tb_mem_access_stage;

  logic        in_CLK = 1'b0;
  logic        in_CLR_N;
  logic        in_EN;
  logic        in_memread;
  logic        in_memwrite;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_mem_ack;
  logic [31:0] in_mem_rdata;
  logic        out_mem_req;
  logic        out_mem_we;
  logic [31:0] out_mem_addr;
  logic [3:0]  out_mem_be;
  logic [31:0] out_mem_wdata;
  logic [31:0] out_Memdata;
  logic        out_stall;
  logic        out_misalign;

  mem_access_stage dut (
    .in_CLK       (in_CLK),
    .in_CLR_N     (in_CLR_N),
    .in_EN        (in_EN),
    .in_memread   (in_memread),
    .in_memwrite  (in_memwrite),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_mem_ack   (in_mem_ack),
    .in_mem_rdata (in_mem_rdata),
    .out_mem_req  (out_mem_req),
    .out_mem_we   (out_mem_we),
    .out_mem_addr (out_mem_addr),
    .out_mem_be   (out_mem_be),
    .out_mem_wdata(out_mem_wdata),
    .out_Memdata  (out_Memdata),
    .out_stall    (out_stall),
    .out_misalign (out_misalign)
  );

  always #5 in_CLK = ~in_CLK;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] wexp;
    logic [31:0] md;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  vec_t        vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_CLK);
    #1;
  endtask

  task automatic clear_op();
    in_memread  = 1'b0;
    in_memwrite = 1'b0;
    in_EN       = 1'b0;
    in_mem_ack  = 1'b0;
  endtask

  // One complete transaction: present op, check request, ack after v.waits, check result
  task automatic run_op(input vec_t v, input int idx);
    int   stalls;
    int   w;
    logic done;
    logic [31:0] exp_md;
    in_memread  = v.rd;
    in_memwrite = v.wr;
    in_size     = v.size;
    in_unsigned = v.uns;
    in_addr     = v.addr;
    in_wdata    = v.wdata;
    in_EN       = 1'b0;
    in_mem_ack  = 1'b0;
    sb_q.push_back(v.md);
    #1;
    chk($sformatf("v%0d_stall_c0", idx), 32'(out_stall), 32'd1);
    chk($sformatf("v%0d_misalign", idx), 32'(out_misalign), 32'd0);
    tick();
    chk($sformatf("v%0d_req", idx), 32'(out_mem_req), 32'd1);
    chk($sformatf("v%0d_we", idx), 32'(out_mem_we), 32'(v.wr));
    chk($sformatf("v%0d_addr", idx), out_mem_addr, {v.addr[31:2], 2'b00});
    chk($sformatf("v%0d_be", idx), 32'(out_mem_be), 32'(v.be));
    if (v.wr) chk($sformatf("v%0d_wdata", idx), out_mem_wdata, v.wexp);
    stalls = 1;
    w      = 0;
    done   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!out_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      in_mem_ack   = (w == v.waits);
      in_mem_rdata = in_mem_ack ? v.rdata : $urandom;
      w++;
      tick();
    end
    in_mem_ack = 1'b0;
    chk($sformatf("v%0d_done_in_time", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(2 + v.waits));
    chk($sformatf("v%0d_req_cleared", idx), 32'(out_mem_req), 32'd0);
    chk($sformatf("v%0d_we_cleared", idx), 32'(out_mem_we), 32'd0);
    if (sb_q.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
    end else begin
      exp_md = sb_q.pop_front();
      chk($sformatf("v%0d_memdata", idx), out_Memdata, exp_md);
    end
    in_EN = 1'b1;
    tick();
    clear_op();
  endtask

  initial begin
    logic [31:0] held;

    vt[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vt[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vt[2] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 4'b1000, 32'h0,         32'h0000_0080};
    vt[3] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 3, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080};
    vt[4] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,         32'h8001_7FFF, 0, 4'b1100, 32'h0,         32'hFFFF_8001};
    vt[5] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,         32'h8001_F00F, 1, 4'b0011, 32'h0,         32'h0000_F00F};
    vt[6] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_F00F};
    vt[7] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,         32'h0000_7F00, 2, 4'b0010, 32'h0,         32'h0000_007F};
    vt[8] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         0, 4'b1111, 32'hCAFE_F00D, 32'h0000_007F};
    vt[9] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 0, 4'b1111, 32'h0,         32'h1234_5678};

    in_CLR_N     = 1'b0;
    in_size      = 2'b00;
    in_unsigned  = 1'b0;
    in_addr      = 32'h0;
    in_wdata     = 32'h0;
    in_mem_rdata = 32'h0;
    clear_op();
    tick();
    tick();
    chk("rst_req", 32'(out_mem_req), 32'd0);
    chk("rst_be", 32'(out_mem_be), 32'd0);
    chk("rst_memdata", out_Memdata, 32'd0);
    chk("rst_stall", 32'(out_stall), 32'd0);
    in_CLR_N = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_op(vt[i], i);

    // Result held with in_EN low in DONE; ack during DONE is ignored
    in_memread  = 1'b1;
    in_size     = 2'b10;
    in_unsigned = 1'b0;
    in_addr     = 32'h0000_0040;
    tick();
    chk("hold_req", 32'(out_mem_req), 32'd1);
    in_mem_ack   = 1'b1;
    in_mem_rdata = 32'h55AA_55AA;
    tick();
    held = out_Memdata;
    chk("hold_memdata", held, 32'h55AA_55AA);
    for (int k = 0; k < 4; k++) begin
      in_mem_ack   = 1'b1;
      in_mem_rdata = $urandom;
      tick();
      chk($sformatf("hold_c%0d_req", k), 32'(out_mem_req), 32'd0);
      chk($sformatf("hold_c%0d_stall", k), 32'(out_stall), 32'd0);
      chk($sformatf("hold_c%0d_memdata", k), out_Memdata, 32'h55AA_55AA);
    end
    in_mem_ack = 1'b0;
    in_EN      = 1'b1;
    tick();
    in_EN = 1'b0;
    chk("hold_exit_stall", 32'(out_stall), 32'd1);
    chk("hold_exit_req", 32'(out_mem_req), 32'd0);
    clear_op();
    tick();

    // Word load at a non-word-aligned address
    in_memread  = 1'b1;
    in_size     = 2'b10;
    in_addr     = 32'h0000_0102;
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    chk("mis_flag", 32'(out_misalign), 32'd1);
    chk("mis_stall", 32'(out_stall), 32'd0);
    tick();
    chk("mis_req", 32'(out_mem_req), 32'd0);
    chk("mis_memdata", out_Memdata, 32'h55AA_55AA);
    clear_op();
    tick();
`else
    clear_op();
    run_op('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'h0BAD_F00D, 0,
             4'b1111, 32'h0, 32'h0BAD_F00D}, 10);
    tick();
`endif

    // Asynchronous reset while a request is outstanding
    in_memwrite = 1'b1;
    in_size     = 2'b10;
    in_addr     = 32'h0000_0500;
    in_wdata    = 32'h0F0F_0F0F;
    tick();
    chk("rstmid_req_before", 32'(out_mem_req), 32'd1);
    in_CLR_N = 1'b0;
    #1;
    chk("rstmid_req", 32'(out_mem_req), 32'd0);
    chk("rstmid_we", 32'(out_mem_we), 32'd0);
    chk("rstmid_be", 32'(out_mem_be), 32'd0);
    chk("rstmid_memdata", out_Memdata, 32'd0);
    clear_op();
    #2;
    in_CLR_N = 1'b1;
    tick();
    chk("rstmid_idle_req", 32'(out_mem_req), 32'd0);
    chk("rstmid_idle_stall", 32'(out_stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
